// File: rtl/id_ex_pkg.sv
// Shared encodings for the ID->EX pipeline register: op classes, ALU selects,
// MEM ops, the decoded control struct and the holding-FSM states.
package id_ex_pkg;
    typedef enum logic [2:0] {
        EX_HIGH_SPECIAL = 3'd0, EX_HIGH_LOGIC = 3'd1, EX_HIGH_SHIFT  = 3'd2, EX_HIGH_ARITH  = 3'd3,
        EX_HIGH_MOVE    = 3'd4, EX_HIGH_LOAD  = 3'd5, EX_HIGH_STORE  = 3'd6, EX_HIGH_BRANCH = 3'd7
    } ex_high_e;

    typedef enum logic [2:0] {
        ALU_NOP = 3'd0, ALU_LOGIC = 3'd1, ALU_SHIFT = 3'd2, ALU_ARITH = 3'd3, ALU_MOVE = 3'd4, ALU_LINK = 3'd5
    } alu_sel_e;

    typedef enum logic [2:0] {
        MEM_OP_NOP = 3'd0, MEM_OP_WRITE_REG = 3'd1, MEM_OP_LOAD = 3'd2, MEM_OP_STORE = 3'd3
    } mem_op_e;

    typedef struct packed {
        alu_sel_e alusel;
        mem_op_e  memop;
        logic     we;
    } ctl_t;

    localparam ctl_t CTL_NOP = '{ALU_NOP, MEM_OP_NOP, 1'b0};

    typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_ONE = 2'd1, ST_FULL = 2'd2} state_e;
endpackage

// File: rtl/id_ex_stage_if.sv
// ID-side and EX-side handshake/payload bundle for id_ex_stage.
interface id_ex_stage_if #(
    parameter int INST_W     = 32,
    parameter int WORD_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int EXOP_HI_W  = 3,
    parameter int EXOP_LO_W  = 5
);
    logic                           id_valid;
    logic                           id_ready;
    logic [INST_W-1:0]              id_inst;
    logic [EXOP_HI_W+EXOP_LO_W-1:0] id_exop;
    logic [WORD_W-1:0]              id_srcLeft;
    logic [WORD_W-1:0]              id_srcRight;
    logic [REG_ADDR_W-1:0]          id_dest;
    logic                           ex_valid;
    logic                           ex_ready;
    logic [INST_W-1:0]              ex_inst;
    logic [2:0]                     ex_alusel;
    logic [EXOP_LO_W-1:0]           ex_aluop;
    logic [WORD_W-1:0]              ex_srcLeft;
    logic [WORD_W-1:0]              ex_srcRight;
    logic [2:0]                     ex_memop;
    logic [REG_ADDR_W-1:0]          ex_dest;
    logic                           ex_writeEnable;

    modport master (
        output id_valid, id_inst, id_exop, id_srcLeft, id_srcRight, id_dest, ex_ready,
        input  id_ready, ex_valid, ex_inst, ex_alusel, ex_aluop, ex_srcLeft, ex_srcRight,
               ex_memop, ex_dest, ex_writeEnable
    );
    modport slave (
        input  id_valid, id_inst, id_exop, id_srcLeft, id_srcRight, id_dest, ex_ready,
        output id_ready, ex_valid, ex_inst, ex_alusel, ex_aluop, ex_srcLeft, ex_srcRight,
               ex_memop, ex_dest, ex_writeEnable
    );
endinterface

// File: rtl/id_ex_decode.sv
// Op-class decode into ALU select, MEM op and register write enable.
module id_ex_decode
    import id_ex_pkg::*;
#(
    parameter int EXOP_HI_W  = 3,
    parameter int REG_ADDR_W = 5
) (
    input  logic [EXOP_HI_W-1:0]  i_class,
    input  logic [REG_ADDR_W-1:0] i_dest,
    output ctl_t                  o_ctl
);
    always_comb begin
        o_ctl = CTL_NOP;
        case (i_class)
            EXOP_HI_W'(EX_HIGH_LOGIC):  o_ctl = '{ALU_LOGIC, MEM_OP_WRITE_REG, 1'b1};
            EXOP_HI_W'(EX_HIGH_SHIFT):  o_ctl = '{ALU_SHIFT, MEM_OP_WRITE_REG, 1'b1};
            EXOP_HI_W'(EX_HIGH_ARITH):  o_ctl = '{ALU_ARITH, MEM_OP_WRITE_REG, 1'b1};
            EXOP_HI_W'(EX_HIGH_MOVE):   o_ctl = '{ALU_MOVE,  MEM_OP_WRITE_REG, 1'b1};
            EXOP_HI_W'(EX_HIGH_LOAD):   o_ctl = '{ALU_ARITH, MEM_OP_LOAD,      1'b1};
            EXOP_HI_W'(EX_HIGH_STORE):  o_ctl = '{ALU_ARITH, MEM_OP_STORE,     1'b0};
            EXOP_HI_W'(EX_HIGH_BRANCH): o_ctl = '{ALU_LINK,  MEM_OP_WRITE_REG, 1'b1};
            default:                    o_ctl = CTL_NOP;
        endcase
        // r0 is hardwired, so nothing may write it
        if (i_dest == '0) o_ctl.we = 1'b0;
    end
endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register: valid/ready handshake, flush, optional 2-entry
// skid buffer and a saturating EX bubble counter.
module id_ex_stage
    import id_ex_pkg::*;
#(
    parameter int INST_W     = 32,
    parameter int WORD_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int EXOP_HI_W  = 3,
    parameter int EXOP_LO_W  = 5,
    parameter bit SKID       = 1'b1,
    parameter int BUB_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    id_ex_stage_if.slave      bus,
    output logic [BUB_W-1:0]  bubble_cnt
);
    typedef struct packed {
        logic [INST_W-1:0]     inst;
        logic [EXOP_LO_W-1:0]  aluop;
        logic [WORD_W-1:0]     srcl;
        logic [WORD_W-1:0]     srcr;
        logic [REG_ADDR_W-1:0] dest;
        ctl_t                  ctl;
    } ent_t;

    state_e           r_state, w_nxt;
    ent_t             r_main, r_skid, w_new;
    ctl_t             w_ctl;
    logic             r_ready, w_ready, w_main_vld, w_acc, w_cons;
    logic             w_ld_main_new, w_ld_main_skid, w_ld_skid;
    logic [BUB_W-1:0] r_bub;

    id_ex_decode #(.EXOP_HI_W(EXOP_HI_W), .REG_ADDR_W(REG_ADDR_W)) u_dec (
        .i_class (bus.id_exop[EXOP_HI_W+EXOP_LO_W-1 -: EXOP_HI_W]),
        .i_dest  (bus.id_dest),
        .o_ctl   (w_ctl)
    );

    assign w_new = '{inst: bus.id_inst, aluop: bus.id_exop[EXOP_LO_W-1:0], srcl: bus.id_srcLeft,
                     srcr: bus.id_srcRight, dest: bus.id_dest, ctl: w_ctl};

    assign w_main_vld = (r_state != ST_EMPTY);
    // Skid mode breaks the ex_ready->id_ready path; single-slot mode passes it through
    assign w_ready    = SKID ? r_ready : (!w_main_vld || bus.ex_ready);
    assign w_acc      = bus.id_valid && w_ready;
    assign w_cons     = w_main_vld && bus.ex_ready;

    always_comb begin
        w_nxt          = r_state;
        w_ld_main_new  = 1'b0;
        w_ld_main_skid = 1'b0;
        w_ld_skid      = 1'b0;
        case (r_state)
            ST_EMPTY: if (w_acc) begin w_nxt = ST_ONE; w_ld_main_new = 1'b1; end
            ST_ONE: begin
                if (w_acc && w_cons) w_ld_main_new = 1'b1;
                else if (w_acc) begin w_nxt = ST_FULL; w_ld_skid = 1'b1; end
                else if (w_cons) w_nxt = ST_EMPTY;
            end
            ST_FULL: if (w_cons) begin w_nxt = ST_ONE; w_ld_main_skid = 1'b1; end
            default: w_nxt = ST_EMPTY;
        endcase
        if (flush) begin
            w_nxt          = ST_EMPTY;
            w_ld_main_new  = 1'b0;
            w_ld_main_skid = 1'b0;
            w_ld_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_EMPTY;
            r_ready <= 1'b0;
            r_main  <= '0;
            r_skid  <= '0;
            r_bub   <= '0;
        end else begin
            r_state <= w_nxt;
            r_ready <= (w_nxt != ST_FULL);
            if (w_ld_main_new)       r_main <= w_new;
            else if (w_ld_main_skid) r_main <= r_skid;
            if (w_ld_skid)           r_skid <= w_new;
            if (bus.ex_ready && !w_main_vld && (r_bub != '1)) r_bub <= r_bub + 1'b1;
        end
    end

    assign bus.id_ready       = w_ready;
    assign bus.ex_valid       = w_main_vld;
    assign bus.ex_inst        = r_main.inst;
    assign bus.ex_aluop       = r_main.aluop;
    assign bus.ex_srcLeft     = r_main.srcl;
    assign bus.ex_srcRight    = r_main.srcr;
    assign bus.ex_dest        = r_main.dest;
    assign bus.ex_alusel      = w_main_vld ? r_main.ctl.alusel : ALU_NOP;
    assign bus.ex_memop       = w_main_vld ? r_main.ctl.memop  : MEM_OP_NOP;
    assign bus.ex_writeEnable = w_main_vld && r_main.ctl.we;
    assign bubble_cnt         = r_bub;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: decode sweep, skid ordering, flush,
// bubble saturation and asynchronous reset.
module tb_id_ex_stage;
    logic clk = 1'b0, rst = 1'b0, rst2 = 1'b0, flush = 1'b0;
    logic [15:0] bub;
    logic [2:0]  bub2;
    int n_chk = 0, n_err = 0;

    always #5 clk = ~clk;

    id_ex_stage_if bus ();
    id_ex_stage_if bus2 ();

    id_ex_stage dut (.clk(clk), .rst(rst), .flush(flush), .bus(bus), .bubble_cnt(bub));
    id_ex_stage #(.SKID(1'b0), .BUB_W(3)) dut2 (.clk(clk), .rst(rst2), .flush(1'b0), .bus(bus2), .bubble_cnt(bub2));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [2:0] cls,
                         input logic [4:0] sub, input logic [4:0] dest);
        bus.id_valid    = v;
        bus.id_inst     = inst;
        bus.id_exop     = {cls, sub};
        bus.id_dest     = dest;
        bus.id_srcLeft  = inst ^ 32'h5555_0000;
        bus.id_srcRight = inst ^ 32'h0000_AAAA;
    endtask

    task automatic dec(input logic [2:0] cls, input logic [4:0] dest,
                       input logic [2:0] ea, input logic [2:0] em, input logic ew);
        drive(1'b1, 32'h100 + 32'(cls), cls, 5'(cls) + 5'd1, dest);
        step();
        chk($sformatf("dec%0d_valid", cls), 32'(bus.ex_valid), 32'd1);
        chk($sformatf("dec%0d_alusel", cls), 32'(bus.ex_alusel), 32'(ea));
        chk($sformatf("dec%0d_memop", cls), 32'(bus.ex_memop), 32'(em));
        chk($sformatf("dec%0d_we", cls), 32'(bus.ex_writeEnable), 32'(ew));
        chk($sformatf("dec%0d_aluop", cls), 32'(bus.ex_aluop), 32'(cls) + 32'd1);
        chk($sformatf("dec%0d_dest", cls), 32'(bus.ex_dest), 32'(dest));
    endtask

    task automatic fill_ab();
        bus.ex_ready = 1'b0;
        drive(1'b1, 32'hA, 3'd3, 5'd1, 5'd1);
        step();
        drive(1'b1, 32'hB, 3'd3, 5'd2, 5'd2);
        step();
        drive(1'b0, 32'h0, 3'd0, 5'd0, 5'd0);
    endtask

    initial begin
        drive(1'b0, 32'h0, 3'd0, 5'd0, 5'd0);
        bus.ex_ready  = 1'b0;
        bus2.id_valid = 1'b0; bus2.id_inst = '0; bus2.id_exop = '0;
        bus2.id_srcLeft = '0; bus2.id_srcRight = '0; bus2.id_dest = '0;
        bus2.ex_ready = 1'b1;
        #1;
        chk("rst_valid", 32'(bus.ex_valid), 32'd0);
        chk("rst_alusel", 32'(bus.ex_alusel), 32'd0);
        chk("rst_memop", 32'(bus.ex_memop), 32'd0);
        chk("rst_we", 32'(bus.ex_writeEnable), 32'd0);
        chk("rst_inst", bus.ex_inst, 32'd0);
        chk("rst_bub", 32'(bub), 32'd0);
        step(); step();
        rst = 1'b1;
        step();
        chk("ready_after_rst", 32'(bus.id_ready), 32'd1);

        // first instruction: LOGIC sub 3 to r4
        bus.ex_ready = 1'b1;
        drive(1'b1, 32'hC0DE, 3'd1, 5'h03, 5'd4);
        step();
        chk("t1_valid", 32'(bus.ex_valid), 32'd1);
        chk("t1_alusel", 32'(bus.ex_alusel), 32'd1);
        chk("t1_aluop", 32'(bus.ex_aluop), 32'd3);
        chk("t1_memop", 32'(bus.ex_memop), 32'd1);
        chk("t1_we", 32'(bus.ex_writeEnable), 32'd1);
        chk("t1_dest", 32'(bus.ex_dest), 32'd4);
        chk("t1_inst", bus.ex_inst, 32'hC0DE);
        chk("t1_srcl", bus.ex_srcLeft, 32'hC0DE ^ 32'h5555_0000);

        // decode sweep, back-to-back with ex_ready=1
        dec(3'd0, 5'd7, 3'd0, 3'd0, 1'b0);
        dec(3'd1, 5'd7, 3'd1, 3'd1, 1'b1);
        dec(3'd2, 5'd7, 3'd2, 3'd1, 1'b1);
        dec(3'd3, 5'd7, 3'd3, 3'd1, 1'b1);
        dec(3'd4, 5'd7, 3'd4, 3'd1, 1'b1);
        dec(3'd5, 5'd7, 3'd3, 3'd2, 1'b1);
        dec(3'd6, 5'd7, 3'd3, 3'd3, 1'b0);
        dec(3'd7, 5'd7, 3'd5, 3'd1, 1'b1);
        dec(3'd3, 5'd0, 3'd3, 3'd1, 1'b0);
        drive(1'b0, 32'h0, 3'd0, 5'd0, 5'd0);
        step();
        chk("drain_valid", 32'(bus.ex_valid), 32'd0);
        chk("drain_alusel_gated", 32'(bus.ex_alusel), 32'd0);
        chk("drain_we_gated", 32'(bus.ex_writeEnable), 32'd0);

        // skid: A then B with EX stalled, then drain in order
        fill_ab();
        chk("skid_ready_full", 32'(bus.id_ready), 32'd0);
        chk("skid_show_a", bus.ex_inst, 32'hA);
        step();
        chk("skid_hold_a", bus.ex_inst, 32'hA);
        bus.ex_ready = 1'b1;
        step();
        chk("skid_b_valid", 32'(bus.ex_valid), 32'd1);
        chk("skid_b_inst", bus.ex_inst, 32'hB);
        chk("skid_ready_back", 32'(bus.id_ready), 32'd1);
        step();
        chk("skid_empty", 32'(bus.ex_valid), 32'd0);

        // flush while FULL with C presented
        fill_ab();
        flush = 1'b1;
        drive(1'b1, 32'hCC, 3'd1, 5'd1, 5'd3);
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 3'd0, 5'd0, 5'd0);
        chk("flush_valid", 32'(bus.ex_valid), 32'd0);
        chk("flush_ready", 32'(bus.id_ready), 32'd1);
        step();
        chk("flush_no_c", 32'(bus.ex_valid), 32'd0);

        // async reset pulse while FULL
        fill_ab();
        chk("pre_rst_valid", 32'(bus.ex_valid), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.ex_valid), 32'd0);
        chk("arst_inst", bus.ex_inst, 32'd0);
        chk("arst_bub", 32'(bub), 32'd0);
        chk("arst_dest", 32'(bus.ex_dest), 32'd0);
        rst = 1'b1;

        // bubble count: 5 idle cycles with EX ready
        bus.ex_ready = 1'b1;
        repeat (5) step();
        chk("bub5", 32'(bub), 32'd5);

        // 3-bit counter saturates at 7
        rst2 = 1'b1;
        repeat (7) step();
        chk("bub2_7", 32'(bub2), 32'd7);
        chk("skid0_ready", 32'(bus2.id_ready), 32'd1);
        repeat (3) step();
        chk("bub2_sat", 32'(bub2), 32'd7);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Parametrised ID→EX pipeline register with valid/ready handshake, synchronous flush and optional 2-entry skid buffer.
- Decodes the exop class field into ALU select, MEM op and write enable for all eight op classes.
- Sits between the ID stage and the EX stage.
- Adds back-pressure handling, hazard flush and a saturating bubble counter for performance debugging.

Parameters:
- INST_W, 32: instruction width.
- WORD_W, 32: operand width.
- REG_ADDR_W, 5: register address width.
- EXOP_HI_W, 3: exop class field width (exop upper bits).
- EXOP_LO_W, 5: ALU sub-op width (exop lower bits).
- SKID, 1: 1 selects a 2-entry skid buffer with registered id_ready; 0 selects a single register with combinational id_ready.
- BUB_W, 16: bubble counter width.

Ports:
- clk  in  1  clock; all state on posedge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- flush  in  1  synchronous kill of all held entries.
- id_valid  in  1  ID presents an instruction.
- id_ready  out  1  stage can accept.
- id_inst  in  INST_W  instruction.
- id_exop  in  EXOP_HI_W+EXOP_LO_W  {class, subop}.
- id_srcLeft  in  WORD_W  left operand.
- id_srcRight  in  WORD_W  right operand.
- id_dest  in  REG_ADDR_W  destination register.
- ex_valid  out  1  EX slot holds an instruction.
- ex_ready  in  1  EX consumes this cycle.
- ex_inst  out  INST_W  instruction.
- ex_alusel  out  3  ALU select.
- ex_aluop  out  EXOP_LO_W  ALU sub-op.
- ex_srcLeft  out  WORD_W  left operand.
- ex_srcRight  out  WORD_W  right operand.
- ex_memop  out  3  MEM op.
- ex_dest  out  REG_ADDR_W  destination register.
- ex_writeEnable  out  1  register write enable.
- bubble_cnt  out  BUB_W  count of cycles with ex_ready=1 and ex_valid=0.

Behaviour:
- Reset (rst=0, async): all valid bits cleared; ex_inst=0, srcs=0, ex_dest=0, ex_aluop=0, ex_alusel=ALU_NOP, ex_memop=MEM_OP_NOP, ex_writeEnable=0, bubble_cnt=0. id_ready=1 from the first clock after release.
- Accept: id_valid&&id_ready. Consume: ex_valid&&ex_ready. Latency: accepted instruction appears on ex_* the next cycle when the main slot is empty or being consumed.
- Class decode (done at accept, registered):
  - LOGIC, SHIFT, ARITH, MOVE → alusel of the same name, MEM_OP_WRITE_REG, we=1.
  - LOAD → ALU_ARITH, MEM_OP_LOAD, we=1.
  - STORE → ALU_ARITH, MEM_OP_STORE, we=0.
  - BRANCH → ALU_LINK, MEM_OP_WRITE_REG, we=1.
  - SPECIAL and undefined codes → ALU_NOP, MEM_OP_NOP, we=0.
  - we is additionally forced to 0 whenever id_dest==0.
- Gating: when ex_valid=0, ex_alusel=ALU_NOP, ex_memop=MEM_OP_NOP, ex_writeEnable=0. Other payload holds its last value.
- SKID=1:
  - States EMPTY (main=0, skid=0), ONE (main=1, skid=0), FULL (main=1, skid=1).
  - id_ready = !skid_valid (registered, no combinational path from ex_ready).
  - EMPTY + accept → ONE.
  - ONE + accept + consume → ONE with new payload.
  - ONE + accept, no consume → FULL; the new entry goes to skid.
  - ONE + consume, no accept → EMPTY.
  - FULL + consume → ONE; skid moves to main. id_ready=0 in FULL, so no accept.
  - Order is strictly FIFO.
- SKID=0: single slot. id_ready = !ex_valid || ex_ready. Accept loads the slot.
- flush=1:
  - Next state is EMPTY. Any accept in that cycle is dropped; any consume that cycle still counts for EX.
  - flush dominates accept.
  - id_ready=1 in the cycle after flush.
- bubble_cnt increments when ex_ready=1 and ex_valid=0. It saturates at all-ones and is never cleared except by rst.
- Reset asserted mid-stream drops all entries immediately.

Decomposition:
- Package id_ex_pkg holds:
  - EX_HIGH_* class codes (SPECIAL=0, LOGIC=1, SHIFT=2, ARITH=3, MOVE=4, LOAD=5, STORE=6, BRANCH=7).
  - ALU_* selects (NOP, LOGIC, SHIFT, ARITH, MOVE, LINK).
  - MEM_OP_* codes (NOP, WRITE_REG, LOAD, STORE).
  - A packed payload struct.
- Sub-module: id_ex_decode (combinational exop class → alusel/memop/we), instantiated once on the input side.

Test Plan:
- Reset release, id_valid=1, exop={LOGIC,5'h03}, dest=4, ex_ready=1 → next cycle: ex_valid=1, alusel=ALU_LOGIC, aluop=3, memop=WRITE_REG, we=1, dest=4.
- Decode sweep, one instruction per class with dest=7 → exact mapping above. Repeat ARITH with dest=0 → we=0. STORE → we=0. Class 0 → ALU_NOP/MEM_OP_NOP.
- SKID=1, ex_ready=0, push A then B:
  - → id_ready=0 after B; ex shows A.
  - Raise ex_ready → A, then B, each consumed in order.
  - id_ready=1 one cycle after A is consumed.
- Flush while FULL, with id_valid=1 presenting C → next cycle ex_valid=0, id_ready=1, C never appears.
- Idle with ex_ready=1 for 5 cycles → bubble_cnt=5. BUB_W=3 with 10 idle cycles → saturates at 7.
- Async reset pulse while FULL (mid-cycle) → outputs reach reset values immediately, without waiting for a clock edge.
